adder_arbiter: RTL
==================

# adder_arbiter

Round-robin scheduler that time-shares one fixed-point `adder` instance between `N_REQ` requesters. Each requester offers an operand pair (a, b) with a valid/ready handshake. The block grants one pair per cycle, registers it into the shared adder, and returns the sum tagged with the requester index over a single valid/ready result port. It sits between per-channel producers and the single adder datapath, so several low-rate channels can use one adder.

## Interface
- `N_REQ`, 4: number of requesters, 2..16
- `A_N_BITS`, 3: operand a width
- `A_BIN_PT`, 1: operand a binary point
- `A_DTYPE`, 1: operand a type, 1 = signed, 0 = unsigned
- `B_N_BITS`, 4: operand b width
- `B_BIN_PT`, 3: operand b binary point
- `B_DTYPE`, 0: operand b type
- `SUM_AB_N_BITS`, 6: sum width
- `SUM_AB_BIN_PT`, 3: sum binary point
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in N_REQ: per-requester operand valid
- `req_ready` out N_REQ: per-requester accept, one-hot or zero
- `req_a` in N_REQ*A_N_BITS: requester i occupies bits [i*A_N_BITS +: A_N_BITS]
- `req_b` in N_REQ*B_N_BITS: same packing as `req_a`
- `res_valid` out 1: result valid
- `res_ready` in 1: result accept
- `res_sum` out SUM_AB_N_BITS: a+b in (SUM_AB_N_BITS, SUM_AB_BIN_PT) format
- `res_id` out clog2(N_REQ): index of the requester that produced `res_sum`

## Operation
- Round-robin pointer `ptr` selects the highest-priority requester. Search order is ptr, ptr+1, …, wrapping modulo N_REQ.
- The grant is combinational. `req_ready[i]` = (i is the first valid index in search order) AND `can_accept`.
- A transfer occurs on a cycle where `req_valid[i]` and `req_ready[i]` are both high.
  - After a transfer, `ptr` = (i+1) mod N_REQ.
  - With no transfer, `ptr` holds.
- `can_accept` = operand stage empty, OR the operand stage advances in this cycle.
- Operand stage holds a_r, b_r, id_r and a valid flag. It feeds `adder` combinationally.
- Alignment, sign extension and width rules are those of `adder`. Overflow wraps; no saturation.
- The result holds stable while `res_valid` is high and `res_ready` is low. The whole pipeline stalls and all `req_ready` bits are low.
- `req_valid` may drop without a transfer. No requester state is kept.
- A requester that holds `req_valid` high is served within N_REQ grants.

## Timing
- Reset values: `req_ready` = 0, `res_valid` = 0, `res_sum` = 0, `res_id` = 0, `ptr` = 0, all stage valid flags cleared.
- Reset asserted mid-operation discards in-flight results. After reset deasserts, the first grant searches from index 0.
- Latency, macro off: transfer at edge t gives `res_valid` = 1 after edge t.
  - Result comes straight from the operand stage through the adder.
  - Throughput is one result per cycle under continuous `res_ready`.
- Latency, macro on: `res_valid` = 1 after edge t+1. Throughput is still one per cycle.
- Simultaneous accept and drain in the same cycle is legal; the stage refills with no bubble.

## Configuration
- `ADDER_ARBITER_OUT_REG_EN` defined:
  - An extra result register follows the adder; latency is 2 cycles.
  - The operand stage advances when the result register is empty or draining.
  - All outputs come from flops.
- `ADDER_ARBITER_OUT_REG_EN` undefined:
  - `res_sum` is combinational from the operand registers through the adder; latency is 1 cycle.
  - `res_valid` and `res_id` come from flops.

## Structure
- `adder_arbiter_pkg` holds:
  - a `clog2` function
  - the `ID_W` constant derived from N_REQ
  - default fixed-point format constants shared with `adder` users
- Sub-module `rr_arbiter` (parameter N_REQ):
  - inputs: request vector, enable
  - outputs: one-hot grant, granted index
  - owns the pointer register
- `adder` is instantiated unchanged as the datapath.

## Test plan
- Single requester 0, a=3'b000, b=4'b0001, `res_ready`=1 -> `res_sum`=6'b000001 (1/8), `res_id`=0, one cycle after transfer (two with macro).
- Requesters 1, 2, 3 send in consecutive cycles, each with a=3'b111 (-1/2), b=4'b0001 -> three results, `res_sum`=6'b111101 (-3/8), `res_id` = 1, 2, 3 in order, one per cycle.
- All four requesters held valid for 8 cycles -> grant order 0, 1, 2, 3, 0, 1, 2, 3.
- Requester 2 sends a=3'b110 (-1), b=4'b0100 (1/2), with `res_ready`=0 for 3 cycles:
  - `res_sum`=6'b111100 (-1/2) holds stable.
  - All `req_ready`=0 during the stall.
  - Exactly one result once `res_ready`=1.
- Requester 3 sends a=3'b001 (1/2), b=4'b1000 (1) -> `res_sum`=6'b001100 (3/2). Then assert `rst` with a result pending -> `res_valid`=0 immediately, and the next grant goes to requester 0.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the adder_arbiter slice.
package adder_arbiter_pkg;

    // Ceiling log2, minimum 0; used to size requester indices.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = n - 1;
        r = 0;
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int unsigned imax(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    localparam int unsigned N_REQ_DEF         = 4;
    localparam int unsigned ID_W              = clog2(N_REQ_DEF);

    // Default fixed-point formats shared with adder users.
    localparam int unsigned A_N_BITS_DEF      = 3;
    localparam int unsigned A_BIN_PT_DEF      = 1;
    localparam int unsigned A_DTYPE_DEF       = 1;
    localparam int unsigned B_N_BITS_DEF      = 4;
    localparam int unsigned B_BIN_PT_DEF      = 3;
    localparam int unsigned B_DTYPE_DEF       = 0;
    localparam int unsigned SUM_AB_N_BITS_DEF = 6;
    localparam int unsigned SUM_AB_BIN_PT_DEF = 3;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and result handshake bundle for adder_arbiter.
interface adder_arbiter_if
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned A_N_BITS   = A_N_BITS_DEF,
    parameter int unsigned B_N_BITS   = B_N_BITS_DEF,
    parameter int unsigned SUM_N_BITS = SUM_AB_N_BITS_DEF,
    parameter int unsigned ID_BITS    = clog2(N_REQ)
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*A_N_BITS-1:0] req_a;
    logic [N_REQ*B_N_BITS-1:0] req_b;
    logic                      res_valid;
    logic                      res_ready;
    logic [SUM_N_BITS-1:0]     res_sum;
    logic [ID_BITS-1:0]        res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id
    );
endinterface

// File: rtl/adder.sv
// Fixed-point adder: aligns both operands to the finer binary point,
// sign- or zero-extends per type, then rescales into the sum format (wrapping).
module adder
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned A_N_BITS      = A_N_BITS_DEF,
    parameter int unsigned A_BIN_PT      = A_BIN_PT_DEF,
    parameter int unsigned A_DTYPE       = A_DTYPE_DEF,
    parameter int unsigned B_N_BITS      = B_N_BITS_DEF,
    parameter int unsigned B_BIN_PT      = B_BIN_PT_DEF,
    parameter int unsigned B_DTYPE       = B_DTYPE_DEF,
    parameter int unsigned SUM_AB_N_BITS = SUM_AB_N_BITS_DEF,
    parameter int unsigned SUM_AB_BIN_PT = SUM_AB_BIN_PT_DEF
) (
    input  logic [A_N_BITS-1:0]      a,
    input  logic [B_N_BITS-1:0]      b,
    output logic [SUM_AB_N_BITS-1:0] sum_ab
);
    localparam int unsigned FP = imax(A_BIN_PT, B_BIN_PT);
    localparam int unsigned EW = A_N_BITS + B_N_BITS + SUM_AB_N_BITS + SUM_AB_BIN_PT + 2;

    logic signed [EW-1:0] a_ext;
    logic signed [EW-1:0] b_ext;
    logic signed [EW-1:0] s_full;
    logic signed [EW-1:0] s_scaled;

    // Extend and align operands, full-precision sum.
    always_comb begin
        a_ext  = (A_DTYPE != 0) ? EW'(signed'(a)) : EW'(a);
        b_ext  = (B_DTYPE != 0) ? EW'(signed'(b)) : EW'(b);
        s_full = (a_ext <<< (FP - A_BIN_PT)) + (b_ext <<< (FP - B_BIN_PT));
    end

    // Move the binary point to the output format.
    if (SUM_AB_BIN_PT >= FP) begin : g_up
        assign s_scaled = s_full <<< (SUM_AB_BIN_PT - FP);
    end else begin : g_dn
        assign s_scaled = s_full >>> (FP - SUM_AB_BIN_PT);
    end

    assign sum_ab = SUM_AB_N_BITS'(s_scaled);
endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin grant over a request vector; owns the priority pointer.
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic                      en,
    output logic [N_REQ-1:0]          gnt,
    output logic [clog2(N_REQ)-1:0]   gnt_id
);
    localparam int unsigned IDW = clog2(N_REQ);

    logic [IDW-1:0] ptr;

    // First active request searching ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        int unsigned    j;
        logic           found;
        logic [IDW-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        j      = 0;
        idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            idx = IDW'(j);
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        if (found && en) gnt[gnt_id] = 1'b1;
    end

    // Pointer moves just past the winner on a transfer, else holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin time-sharing of one fixed-point adder between N_REQ requesters.
// ADDER_ARBITER_OUT_REG_EN: adds a result register after the adder (2-cycle latency).
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ         = N_REQ_DEF,
    parameter int unsigned A_N_BITS      = A_N_BITS_DEF,
    parameter int unsigned A_BIN_PT      = A_BIN_PT_DEF,
    parameter int unsigned A_DTYPE       = A_DTYPE_DEF,
    parameter int unsigned B_N_BITS      = B_N_BITS_DEF,
    parameter int unsigned B_BIN_PT      = B_BIN_PT_DEF,
    parameter int unsigned B_DTYPE       = B_DTYPE_DEF,
    parameter int unsigned SUM_AB_N_BITS = SUM_AB_N_BITS_DEF,
    parameter int unsigned SUM_AB_BIN_PT = SUM_AB_BIN_PT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);
    localparam int unsigned IDW = clog2(N_REQ);

    logic [N_REQ-1:0]         gnt;
    logic [IDW-1:0]           gnt_id;
    logic                     can_accept;
    logic                     xfer;
    logic                     stage_adv;
    logic [A_N_BITS-1:0]      a_r;
    logic [B_N_BITS-1:0]      b_r;
    logic [IDW-1:0]           id_r;
    logic                     v_r;
    logic [SUM_AB_N_BITS-1:0] sum_c;

    // Grant is suppressed during reset so req_ready reads zero.
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .en     (can_accept & ~rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign bus.req_ready = gnt;
    assign xfer          = |gnt;
    assign can_accept    = ~v_r | stage_adv;

    // Operand stage: load on a grant, clear when it drains without a refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            id_r <= '0;
            v_r  <= 1'b0;
        end else if (xfer) begin
            a_r  <= bus.req_a[gnt_id*A_N_BITS +: A_N_BITS];
            b_r  <= bus.req_b[gnt_id*B_N_BITS +: B_N_BITS];
            id_r <= gnt_id;
            v_r  <= 1'b1;
        end else if (stage_adv) begin
            v_r  <= 1'b0;
        end
    end

    adder #(
        .A_N_BITS      (A_N_BITS),
        .A_BIN_PT      (A_BIN_PT),
        .A_DTYPE       (A_DTYPE),
        .B_N_BITS      (B_N_BITS),
        .B_BIN_PT      (B_BIN_PT),
        .B_DTYPE       (B_DTYPE),
        .SUM_AB_N_BITS (SUM_AB_N_BITS),
        .SUM_AB_BIN_PT (SUM_AB_BIN_PT)
    ) u_adder (
        .a      (a_r),
        .b      (b_r),
        .sum_ab (sum_c)
    );

`ifdef ADDER_ARBITER_OUT_REG_EN
    logic                     out_v;
    logic                     out_adv;
    logic [SUM_AB_N_BITS-1:0] out_sum;
    logic [IDW-1:0]           out_id;

    assign out_adv   = ~out_v | bus.res_ready;
    assign stage_adv = v_r & out_adv;

    // Result register: refill from the operand stage whenever empty or draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v   <= 1'b0;
            out_sum <= '0;
            out_id  <= '0;
        end else if (out_adv) begin
            out_v <= v_r;
            if (v_r) begin
                out_sum <= sum_c;
                out_id  <= id_r;
            end
        end
    end

    assign bus.res_valid = out_v;
    assign bus.res_sum   = out_sum;
    assign bus.res_id    = out_id;
`else
    assign stage_adv     = v_r & bus.res_ready;
    assign bus.res_valid = v_r;
    assign bus.res_sum   = sum_c;
    assign bus.res_id    = id_r;
`endif
endmodule
